tri_raster: RTL
===============

Name: tri_raster

Overview:
- Rasterization stage that sits directly downstream of the projection stage.
- Accepts one projected screen-space triangle (three 10-bit x/y vertices, clip flag, 6-bit light/shade value) through a valid/ready handshake.
- Walks the triangle's screen-clamped bounding box in row-major order and tests each pixel centre against three edge functions.
- Emits each covered pixel (x, y, colour) on a valid/ready stream toward the framebuffer writer.

Parameters:
- SCR_W, 640, screen width in pixels; bounding-box x is clamped to SCR_W-1.
- SCR_H, 480, screen height in pixels; bounding-box y is clamped to SCR_H-1.
- CW, 6, colour/shade width; matches the light stage output.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- tri_valid  in  1  upstream triangle available.
- tri_ready  out  1  block can accept a triangle.
- proj_triangle  in  [2:0][1:0][9:0]  vertices; [i][0]=x, [i][1]=y, unsigned.
- clip  in  1  triangle out of screen bounds; drop it.
- shade  in  CW  flat colour for the whole triangle.
- pix_valid  out  1  pix_x/pix_y/pix_color hold a covered pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  10  pixel column.
- pix_y  out  10  pixel row.
- pix_color  out  CW  latched shade.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a triangle finishes, whether rasterized or dropped.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. tri_ready=1. pix_valid=0. pix_x=pix_y=0. pix_color=0. busy=0. done=0. All internal registers cleared.
- Reset asserted mid-triangle aborts it immediately. No done pulse is produced for the aborted triangle.

States: IDLE -> SETUP -> (SCAN | DONE) -> DONE -> IDLE.
- IDLE:
  - tri_ready=1.
  - On tri_valid&&tri_ready (cycle T): register the vertices, clip and shade; go to SETUP.
- SETUP (T+1):
  - Compute bbox: xmin/xmax/ymin/ymax over the three vertices, with xmax clamped to SCR_W-1 and ymax to SCR_H-1. The clamp is also applied to xmin/ymin.
  - Compute area = E01(v2).
  - Compute initial edge values E01, E12, E20 at (xmin, ymin).
  - If clip=1 or area==0, go to DONE. Otherwise go to SCAN with cur=(xmin, ymin).
- SCAN:
  - Edge function, with signed arithmetic throughout: Eij(p) = (xj-xi)*(py-yi) - (yj-yi)*(px-xi).
  - Operand widths: differences 11-bit signed, products 22-bit, sums 23-bit signed.
  - inside = each of E01, E12, E20 is zero or has the same sign as area. Edges count as inside, so winding order is irrelevant.
  - pix_valid = inside (combinational from registered state). pix_x/pix_y = cur; pix_color = latched shade.
  - Advance (cur and edges updated incrementally, with no multipliers in SCAN) when !inside or pix_ready.
  - With pix_valid=1 and pix_ready=0: hold cur, edges and outputs stable.
  - Order: x increments to xmax, then x=xmin and y increments.
  - On advancing from (xmax, ymax), go to DONE.
  - Throughput is one candidate per cycle when pix_ready=1.
- DONE:
  - done=1 for exactly one cycle; pix_valid=0; next state IDLE.
- Boundary conditions:
  - Single-pixel triangle (all vertices equal): area==0, dropped, no pixels emitted.
  - Vertex at x>=SCR_W: pixels beyond SCR_W-1 are never emitted.
  - tri_valid while busy: ignored, since tri_ready=0.
  - A back-to-back triangle is accepted in the cycle after DONE.

Test Plan:
1. Baseline coverage:
   - Stimulus: v0=(0,0), v1=(4,0), v2=(0,4), shade=6'h2A, clip=0, pix_ready=1, accepted at T.
   - Required response: exactly 15 pixels satisfying x+y<=4.
   - First pixel (0,0) at T+2; last pixel (0,4).
   - pix_color=6'h2A on every pixel.
   - done pulse at T+27 (25 candidates); tri_ready=1 at T+28.
2. Winding order:
   - Stimulus: the same triangle with v1 and v2 swapped (negative area).
   - Required response: identical 15 pixels in the same order, with identical timing.
3. Drop paths:
   - Stimulus: clip=1; or collinear vertices (0,0), (2,2), (5,5).
   - Required response: no pix_valid; done at T+2; busy high T+1..T+2.
4. Backpressure:
   - Stimulus: scenario 1 with pix_ready held low for 3 cycles while pixel (2,0) is presented.
   - Required response: pix_x=2, pix_y=0 stay stable with pix_valid=1 for the whole stall.
   - Pixel order and count are unchanged; done is delayed 3 cycles, to T+30.
5. Screen clamp:
   - Stimulus: v0=(636,476), v1=(700,476), v2=(636,500).
   - Required response: no pixel has x>639 or y>479.
   - Pixel (639,479) is emitted; scan covers 4x4 candidates.
6. Reset mid-scan:
   - Stimulus: rst_n pulsed low during SCAN of scenario 1.
   - Required response: pix_valid=0, busy=0, tri_ready=1, no done pulse.
   - A new triangle is accepted normally after release.

Source files
------------

// File: rtl/tri_raster.sv
`default_nettype none
// ============================================================================
// Module      : tri_raster
// Description : Flat-shaded triangle rasterizer. Walks the clamped bounding box
//               and emits covered pixels using incrementally updated edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_raster #(
    parameter int SCR_W = 640,
    parameter int SCR_H = 480,
    parameter int CW    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tri_valid,
    output logic                 tri_ready,
    input  logic [2:0][1:0][9:0] proj_triangle,
    input  logic                 clip,
    input  logic [CW-1:0]        shade,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [9:0]           pix_x,
    output logic [9:0]           pix_y,
    output logic [CW-1:0]        pix_color,
    output logic                 busy,
    output logic                 done
);
    localparam logic [9:0] c_x_lim = 10'(SCR_W - 1);
    localparam logic [9:0] c_y_lim = 10'(SCR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0][9:0]    r_vx;
    logic [2:0][9:0]    r_vy;
    logic               r_clip;
    logic [CW-1:0]      r_color;
    logic [9:0]         r_xmin;
    logic [9:0]         r_xmax;
    logic [9:0]         r_ymax;
    logic [9:0]         r_cur_x;
    logic [9:0]         r_cur_y;
    logic               r_area_neg;
    logic signed [22:0] r_e    [3];
    logic signed [22:0] r_erow [3];

    logic [9:0]         w_xmin;
    logic [9:0]         w_xmax;
    logic [9:0]         w_ymin;
    logic [9:0]         w_ymax;
    logic signed [10:0] w_dx     [3];
    logic signed [10:0] w_dy     [3];
    logic signed [22:0] w_e_init [3];
    logic [2:0]         w_pos;
    logic [2:0]         w_neg;
    logic signed [10:0] w_ay;
    logic signed [10:0] w_ax;
    logic signed [21:0] w_area_p;
    logic signed [21:0] w_area_q;
    logic signed [22:0] w_area;
    logic               w_inside;

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                        input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign w_xmin = clamp(min3(r_vx[0], r_vx[1], r_vx[2]), c_x_lim);
    assign w_xmax = clamp(max3(r_vx[0], r_vx[1], r_vx[2]), c_x_lim);
    assign w_ymin = clamp(min3(r_vy[0], r_vy[1], r_vy[2]), c_y_lim);
    assign w_ymax = clamp(max3(r_vy[0], r_vy[1], r_vy[2]), c_y_lim);

    // Edge i runs from vertex i to vertex (i+1)%3: E01, E12, E20.
    for (genvar i = 0; i < 3; i++) begin : g_edge
        localparam int J = (i + 1) % 3;
        logic signed [10:0] w_ox;
        logic signed [10:0] w_oy;
        logic signed [21:0] w_px;
        logic signed [21:0] w_py;

        assign w_dx[i] = $signed({1'b0, r_vx[J]}) - $signed({1'b0, r_vx[i]});
        assign w_dy[i] = $signed({1'b0, r_vy[J]}) - $signed({1'b0, r_vy[i]});
        assign w_ox    = $signed({1'b0, w_xmin}) - $signed({1'b0, r_vx[i]});
        assign w_oy    = $signed({1'b0, w_ymin}) - $signed({1'b0, r_vy[i]});
        assign w_py    = 22'(w_dx[i]) * 22'(w_oy);
        assign w_px    = 22'(w_dy[i]) * 22'(w_ox);
        assign w_e_init[i] = 23'(w_py) - 23'(w_px);
        assign w_pos[i] = !r_e[i][22];
        assign w_neg[i] = r_e[i][22] || (r_e[i] == '0);
    end

    assign w_ay     = $signed({1'b0, r_vy[2]}) - $signed({1'b0, r_vy[0]});
    assign w_ax     = $signed({1'b0, r_vx[2]}) - $signed({1'b0, r_vx[0]});
    assign w_area_p = 22'(w_dx[0]) * 22'(w_ay);
    assign w_area_q = 22'(w_dy[0]) * 22'(w_ax);
    assign w_area   = 23'(w_area_p) - 23'(w_area_q);

    // Zero edges count as inside, so either winding order covers the same pixels.
    assign w_inside = r_area_neg ? (&w_neg) : (&w_pos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vx       <= '0;
            r_vy       <= '0;
            r_clip     <= 1'b0;
            r_color    <= '0;
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_ymax     <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_area_neg <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_e[i]    <= '0;
                r_erow[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tri_valid) begin
                        for (int i = 0; i < 3; i++) begin
                            r_vx[i] <= proj_triangle[i][0];
                            r_vy[i] <= proj_triangle[i][1];
                        end
                        r_clip  <= clip;
                        r_color <= shade;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_xmin     <= w_xmin;
                    r_xmax     <= w_xmax;
                    r_ymax     <= w_ymax;
                    r_cur_x    <= w_xmin;
                    r_cur_y    <= w_ymin;
                    r_area_neg <= w_area[22];
                    for (int i = 0; i < 3; i++) begin
                        r_e[i]    <= w_e_init[i];
                        r_erow[i] <= w_e_init[i];
                    end
                    r_state <= (r_clip || (w_area == '0)) ? S_DONE : S_SCAN;
                end
                S_SCAN: begin
                    if (!w_inside || pix_ready) begin
                        if (r_cur_x == r_xmax) begin
                            if (r_cur_y == r_ymax) begin
                                r_state <= S_DONE;
                            end else begin
                                // Row-start edges avoid a width*step multiply on wrap.
                                r_cur_x <= r_xmin;
                                r_cur_y <= r_cur_y + 10'd1;
                                for (int i = 0; i < 3; i++) begin
                                    r_erow[i] <= r_erow[i] + 23'(w_dx[i]);
                                    r_e[i]    <= r_erow[i] + 23'(w_dx[i]);
                                end
                            end
                        end else begin
                            r_cur_x <= r_cur_x + 10'd1;
                            for (int i = 0; i < 3; i++) begin
                                r_e[i] <= r_e[i] - 23'(w_dy[i]);
                            end
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tri_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign pix_valid = (r_state == S_SCAN) && w_inside;
    assign pix_x     = r_cur_x;
    assign pix_y     = r_cur_y;
    assign pix_color = r_color;

endmodule
`default_nettype wire
